// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the instruction memory block.
//   fault_e : response fault code (OK / misaligned / out of range)
//   state_e : controller state (clearing sweep / normal operation)
//   RV_NOP  : instruction returned on any faulted fetch (addi x0, x0, 0)
package imem_pkg;

    typedef enum logic [1:0] {
        FAULT_OK         = 2'b00,
        FAULT_MISALIGNED = 2'b01,
        FAULT_OOR        = 2'b10
    } fault_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

endpackage

// File: rtl/imem_ram.sv
// imem_ram: DEPTH_WORDS x 32 storage with one synchronous read port and one
// byte-strobed write port. A read and a write to the same word in the same
// cycle return the old contents (read-before-write).
//   clock     : rising-edge clock
//   rd_en     : capture mem[rd_idx] into rd_data at the clock edge
//   rd_idx    : word index to read
//   rd_data   : registered read data, holds while rd_en is low
//   wr_en     : write enable
//   wr_idx    : word index to write
//   wr_data   : write data
//   wr_strb   : byte-lane enables for the write
module imem_ram #(
    parameter  int DEPTH_WORDS = 512,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clock,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_idx,
    output logic [31:0]   rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  logic [31:0]   wr_data,
    input  logic [3:0]    wr_strb
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rd_data_q;

    // Non-blocking read and write in the same edge give read-before-write.
    always_ff @(posedge clock) begin
        if (rd_en) begin
            rd_data_q <= mem[rd_idx];
        end
        if (wr_en) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (wr_strb[lane]) begin
                    mem[wr_idx][lane*8 +: 8] <= wr_data[lane*8 +: 8];
                end
            end
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/imem_fetch_unit.sv
// imem_fetch_unit: instruction memory for the core's fetch stage.
//   clock, reset_n          : clock and asynchronous active-low reset
//   req_valid/ready/addr    : fetch request (byte address)
//   rsp_valid/ready         : fetch response handshake, latency 1
//   rsp_instr, rsp_fault    : fetched word and fault code (NOP on fault)
//   load_valid/ready        : program-load write handshake
//   load_addr/data/strb     : load byte address (low 2 bits ignored), data, lanes
//   load_err                : one-cycle pulse after an out-of-range load
//   init_done               : memory usable (clearing sweep finished)
// After reset the array is zeroed one word per cycle before fetch/load open.
module imem_fetch_unit
    import imem_pkg::*;
#(
    parameter int               XLEN           = 32,
    parameter int               DEPTH_WORDS    = 512,
    parameter logic [XLEN-1:0]  BASE_ADDR      = '0,
    parameter int               CLEAR_ON_RESET = 1
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [31:0]     rsp_instr,
    output logic [1:0]      rsp_fault,
    input  logic            load_valid,
    output logic            load_ready,
    input  logic [XLEN-1:0] load_addr,
    input  logic [31:0]     load_data,
    input  logic [3:0]      load_strb,
    output logic            load_err,
    output logic            init_done
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_e        state_q, state_d;
    logic [AW-1:0] clr_ptr_q, clr_ptr_d;
    logic          rsp_valid_q, rsp_valid_d;
    fault_e        rsp_fault_q, rsp_fault_d;
    logic          rsp_hit_q, rsp_hit_d;     // response comes from the array
    logic          load_err_q, load_err_d;

    logic            run, sweep_we;
    logic            req_fire, load_fire;
    logic [XLEN-1:0] req_off, load_off;
    logic            req_oor, load_oor;
    fault_e          req_fault;
    logic            ram_we;
    logic [AW-1:0]   ram_widx;
    logic [31:0]     ram_wdata, ram_rdata;
    logic [3:0]      ram_wstrb;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_INIT;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            ST_INIT: begin
                if (CLEAR_ON_RESET == 0) begin
                    state_d = ST_RUN;
                end else begin
                    clr_ptr_d = clr_ptr_q + AW'(1);
                    if (clr_ptr_q == AW'(DEPTH_WORDS - 1)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        run      = (state_q == ST_RUN);
        sweep_we = (state_q == ST_INIT) && (CLEAR_ON_RESET != 0);
    end

    // ---------------- address decode ----------------
    // Offsets are XLEN wide; anything below BASE_ADDR is caught separately so a
    // wrapped subtraction can never alias back into the array.
    assign req_off  = req_addr - BASE_ADDR;
    assign load_off = load_addr - BASE_ADDR;
    assign req_oor  = (req_addr < BASE_ADDR)  || ((req_off  >> (AW + 2)) != '0);
    assign load_oor = (load_addr < BASE_ADDR) || ((load_off >> (AW + 2)) != '0);

    always_comb begin
        req_fault = FAULT_OK;
        if (req_addr[1:0] != 2'b00) begin
            req_fault = FAULT_MISALIGNED;
        end else if (req_oor) begin
            req_fault = FAULT_OOR;
        end
    end

    // ---------------- fetch handshake ----------------
    assign req_ready = run && (!rsp_valid_q || rsp_ready);
    assign req_fire  = req_valid && req_ready;

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_fault_d = rsp_fault_q;
        rsp_hit_d   = rsp_hit_q;
        if (req_fire) begin
            rsp_valid_d = 1'b1;
            rsp_fault_d = req_fault;
            rsp_hit_d   = (req_fault == FAULT_OK);
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // ---------------- load port ----------------
    assign load_ready = run;
    assign load_fire  = load_valid && load_ready;
    // An all-zero strobe is a no-op and never reports an error.
    assign load_err_d = load_fire && load_oor && (load_strb != 4'b0000);

    // Sweep owns the write port during INIT; loads own it during RUN.
    always_comb begin
        ram_we    = load_fire && !load_oor;
        ram_widx  = load_off[AW+1:2];
        ram_wdata = load_data;
        ram_wstrb = load_strb;
        if (sweep_we) begin
            ram_we    = 1'b1;
            ram_widx  = clr_ptr_q;
            ram_wdata = '0;
            ram_wstrb = 4'hF;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= FAULT_OK;
            rsp_hit_q   <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_fault_q <= rsp_fault_d;
            rsp_hit_q   <= rsp_hit_d;
            load_err_q  <= load_err_d;
        end
    end

    imem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clock   (clock),
        .rd_en   (req_fire && (req_fault == FAULT_OK)),
        .rd_idx  (req_off[AW+1:2]),
        .rd_data (ram_rdata),
        .wr_en   (ram_we),
        .wr_idx  (ram_widx),
        .wr_data (ram_wdata),
        .wr_strb (ram_wstrb)
    );

    // The array's read register has no reset, so gate it with flops that do;
    // this keeps rsp_instr at 0 while reset_n is low.
    assign rsp_instr = (rsp_fault_q != FAULT_OK) ? RV_NOP :
                       (rsp_hit_q ? ram_rdata : 32'h0000_0000);
    assign rsp_valid = rsp_valid_q;
    assign rsp_fault = rsp_fault_q;
    assign load_err  = load_err_q;
    assign init_done = run;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// tb_imem_fetch_unit: directed bench for imem_fetch_unit with DEPTH_WORDS=16,
// BASE_ADDR=0x100, CLEAR_ON_RESET=1. Inputs change on the falling edge and
// outputs are sampled on the falling edge (or 1 ns after an input change).
module tb_imem_fetch_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [1:0]  rsp_fault;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic [3:0]  load_strb;
    logic        load_err;
    logic        init_done;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 clock = ~clock;

    imem_fetch_unit #(
        .XLEN           (32),
        .DEPTH_WORDS    (16),
        .BASE_ADDR      (32'h0000_0100),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_instr  (rsp_instr),
        .rsp_fault  (rsp_fault),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .load_strb  (load_strb),
        .load_err   (load_err),
        .init_done  (init_done)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_ctl"},
                    {26'b0, req_ready, rsp_valid, rsp_fault, load_ready, load_err, init_done}, 32'h0);
        check_value({tag, "_instr"}, rsp_instr, 32'h0);
    endtask

    // Releases reset on a falling edge and returns the number of rising edges
    // until init_done is observed (bounded).
    task automatic release_and_count(output int n);
        @(negedge clock);
        reset_n = 1'b1;
        n = 0;
        while (!init_done && n < 100) begin
            @(negedge clock);
            n++;
        end
        $display("reset released: init_done after %0d cycles", n);
    endtask

    task automatic do_fetch(input logic [31:0] addr, output logic [31:0] instr, output logic [1:0] fault);
        @(negedge clock);
        req_valid = 1'b1;
        req_addr  = addr;
        rsp_ready = 1'b1;
        #1;
        check_value("fetch_req_ready", {31'b0, req_ready}, 32'h1);
        @(negedge clock);
        req_valid = 1'b0;
        check_value("fetch_rsp_valid", {31'b0, rsp_valid}, 32'h1);
        instr = rsp_instr;
        fault = rsp_fault;
        $display("fetch addr=0x%08h instr=0x%08h fault=%0d", addr, instr, fault);
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic err);
        @(negedge clock);
        load_valid = 1'b1;
        load_addr  = addr;
        load_data  = data;
        load_strb  = strb;
        #1;
        check_value("load_ready", {31'b0, load_ready}, 32'h1);
        @(negedge clock);
        load_valid = 1'b0;
        err = load_err;
        $display("load  addr=0x%08h data=0x%08h strb=%b err=%0d", addr, data, strb, err);
    endtask

    initial begin : stim
        logic [31:0] instr;
        logic [1:0]  fault;
        logic        err;
        int          ncyc;

        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        rsp_ready  = 1'b0;
        load_valid = 1'b0;
        load_addr  = '0;
        load_data  = '0;
        load_strb  = '0;

        // Reset state and sweep timing
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        release_and_count(ncyc);
        check_value("sweep_cycles", ncyc, 32'd16);

        // Every word cleared by the sweep
        for (int i = 0; i < 16; i++) begin
            do_fetch(32'h100 + 32'(4 * i), instr, fault);
            check_value($sformatf("sweep_w%0d_instr", i), instr, 32'h0);
            check_value($sformatf("sweep_w%0d_fault", i), fault, 32'h0);
        end

        // Zero strobe: accepted, no effect, no error
        do_load(32'h104, 32'hFFFF_FFFF, 4'b0000, err);
        check_value("strb0_err", err, 32'h0);

        // Full write then single-lane write
        do_load(32'h108, 32'hDEAD_BEEF, 4'b1111, err);
        check_value("load_full_err", err, 32'h0);
        do_load(32'h108, 32'h0000_0042, 4'b0001, err);
        check_value("load_lane0_err", err, 32'h0);
        do_fetch(32'h108, instr, fault);
        check_value("merge_instr", instr, 32'hDEAD_BE42);
        check_value("merge_fault", fault, 32'h0);

        // Faults
        do_fetch(32'h106, instr, fault);
        check_value("misal_fault", fault, 32'h1);
        check_value("misal_instr", instr, NOP);
        do_fetch(32'h002, instr, fault);
        check_value("misal_prio_fault", fault, 32'h1);
        do_fetch(32'h0FC, instr, fault);
        check_value("below_fault", fault, 32'h2);
        check_value("below_instr", instr, NOP);
        do_fetch(32'h140, instr, fault);
        check_value("above_fault", fault, 32'h2);
        check_value("above_instr", instr, NOP);
        do_fetch(32'h13C, instr, fault);
        check_value("last_word_fault", fault, 32'h0);

        // Out-of-range load: one error pulse, nothing written
        do_load(32'h000, 32'hBAD0_BAD0, 4'b1111, err);
        check_value("oor_load_err", err, 32'h1);
        @(negedge clock);
        check_value("oor_load_err_pulse", {31'b0, load_err}, 32'h0);
        do_fetch(32'h100, instr, fault);
        check_value("oor_load_w0", instr, 32'h0);
        do_fetch(32'h104, instr, fault);
        check_value("strb0_w1", instr, 32'h0);

        // Backpressure
        do_load(32'h100, 32'hA000_0000, 4'b1111, err);
        do_load(32'h104, 32'hA000_0001, 4'b1111, err);
        do_load(32'h108, 32'hA000_0002, 4'b1111, err);
        @(negedge clock);
        req_valid = 1'b1;
        req_addr  = 32'h100;
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        req_addr  = 32'h104;
        #1;
        check_value("bp_valid0", {31'b0, rsp_valid}, 32'h1);
        check_value("bp_instr0", rsp_instr, 32'hA000_0000);
        check_value("bp_ready0", {31'b0, req_ready}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check_value($sformatf("bp_hold%0d_valid", i), {31'b0, rsp_valid}, 32'h1);
            check_value($sformatf("bp_hold%0d_instr", i), rsp_instr, 32'hA000_0000);
            check_value($sformatf("bp_hold%0d_ready", i), {31'b0, req_ready}, 32'h0);
        end
        rsp_ready = 1'b1;
        #1;
        check_value("bp_ready_resume", {31'b0, req_ready}, 32'h1);
        @(negedge clock);
        check_value("bp_valid1", {31'b0, rsp_valid}, 32'h1);
        check_value("bp_instr1", rsp_instr, 32'hA000_0001);
        req_addr = 32'h108;
        @(negedge clock);
        check_value("bp_valid2", {31'b0, rsp_valid}, 32'h1);
        check_value("bp_instr2", rsp_instr, 32'hA000_0002);
        req_valid = 1'b0;
        @(negedge clock);
        check_value("bp_drained", {31'b0, rsp_valid}, 32'h0);
        $display("backpressure sequence done");

        // Same-cycle load and fetch to one word
        do_load(32'h10C, 32'h1111_1111, 4'b1111, err);
        @(negedge clock);
        load_valid = 1'b1;
        load_addr  = 32'h10C;
        load_data  = 32'h2222_2222;
        load_strb  = 4'b1111;
        req_valid  = 1'b1;
        req_addr   = 32'h10C;
        rsp_ready  = 1'b1;
        @(negedge clock);
        load_valid = 1'b0;
        req_valid  = 1'b0;
        check_value("hazard_valid", {31'b0, rsp_valid}, 32'h1);
        check_value("hazard_old", rsp_instr, 32'h1111_1111);
        $display("hazard fetch addr=0x0000010c instr=0x%08h", rsp_instr);
        do_fetch(32'h10C, instr, fault);
        check_value("hazard_new", instr, 32'h2222_2222);

        // Reset with a held faulted response, then reset mid-sweep
        @(negedge clock);
        req_valid = 1'b1;
        req_addr  = 32'h106;
        rsp_ready = 1'b0;
        @(negedge clock);
        req_valid = 1'b0;
        check_value("pre_rst_fault", rsp_fault, 32'h1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clock);
        rsp_ready = 1'b1;
        reset_n   = 1'b1;
        repeat (5) @(negedge clock);
        check_value("mid_sweep_ctl", {29'b0, init_done, req_ready, load_ready}, 32'h0);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mid_sweep_rst");
        release_and_count(ncyc);
        check_value("resweep_cycles", ncyc, 32'd16);
        do_fetch(32'h108, instr, fault);
        check_value("resweep_w2", instr, 32'h0);
        do_fetch(32'h10C, instr, fault);
        check_value("resweep_w3", instr, 32'h0);

        @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
